systolic_matmul_acc: RTL and testbench
======================================

Name: systolic_matmul_acc

Overview:
Parametrised successor to the team's single-shot systolic matrix multiplier. Computes C = A·B (MxK · KxN, signed fixed point) on an MxN output-stationary PE grid. Adds an accumulate mode for K-dimension tiling (C += A·B across runs) and valid/ready backpressure on the C stream. Sits between the attention/linear-layer controller and the activation buffers of the branch-predicting transformer datapath.

Parameters:
DATA_WIDTH, 16, element width (two's complement)
FRAC_WIDTH, 8, fractional bits of A, B and C
M, 4, rows of A and C
N, 2, cols of B and C
K, 3, cols of A / rows of B per run
ACC_GUARD, 4, extra accumulator bits for accumulation across tiles; ACC_WIDTH = 2*DATA_WIDTH + $clog2(K) + ACC_GUARD

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  begin run; honoured only in IDLE
acc_mode  in  1  sampled with start; 1 = keep accumulators, 0 = clear them
a_data  in  DATA_WIDTH  A element
a_row  in  $clog2(M)  A row index
a_col  in  $clog2(K)  A column index
a_valid  in  1  write A element
b_data  in  DATA_WIDTH  B element
b_row  in  $clog2(K)  B row index
b_col  in  $clog2(N)  B column index
b_valid  in  1  write B element
c_data  out  DATA_WIDTH  C element
c_row  out  $clog2(M)  C row index
c_col  out  $clog2(N)  C column index
c_valid  out  1  C element valid
c_ready  in  1  consumer accepts C element
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after the last C element is accepted
ovf  out  1  sticky; C element clipped this run

Behaviour:
- Reset (async, rst_n=0): state IDLE; A/B buffers and all accumulators zeroed; c_data=0, c_row=0, c_col=0, c_valid=0, busy=0, done=0, ovf=0. Reset mid-run aborts immediately; no done pulse.
- A/B writes: accepted only in IDLE, including the start cycle (a write in the start cycle is used by that run). Ignored while busy. Out-of-range indices ignored. a and b ports are independent and may write in the same cycle.
- FSM: IDLE -> (start) FEED -> OUTPUT -> DONE -> IDLE.
- FEED lasts exactly S = M+N+K-2 cycles, step s = 0..S-1. Row-i A stream is skewed by i; column-j B stream is skewed by j. PE(i,j) accumulates A[i][k]*B[k][j] at step s where k = s-i-j and 0<=k<K. Bubbles feed zero.
- acc_mode=0: accumulators cleared on the start edge. acc_mode=1: previous values kept. ovf cleared on start.
- Products are full 2*DATA_WIDTH signed; sums use ACC_WIDTH with no internal wrap.
- Output conversion: arithmetic shift right by FRAC_WIDTH (floor), then narrowed to DATA_WIDTH per SYSTOLIC_SAT_EN.
- OUTPUT: elements leave row-major (0,0),(0,1)...(M-1,N-1). c_valid rises the cycle after the last FEED step, i.e. M+N+K-1 cycles after the start edge. Element advances only on c_valid && c_ready. While c_ready=0, c_data/c_row/c_col are held stable.
- DONE: done=1 for one cycle, busy still 1; next cycle IDLE, busy=0. Accumulators keep their values for a following acc_mode=1 run.
- start while busy: ignored. start and rst_n low in the same cycle: reset wins.

Optional Feature:
SYSTOLIC_SAT_EN
- Defined: out-of-range results clamp to 0x7FFF / 0x8000 (for DATA_WIDTH=16), and ovf is set.
- Undefined: results are truncated to the low DATA_WIDTH bits (wrap), and ovf is tied to 0.

Decomposition:
- systolic_pkg: FSM state enum (IDLE, FEED, OUTPUT, DONE); ACC_WIDTH helper function; fixed-point narrow/saturate function.
- Sub-module systolic_pe: one MAC cell with registered a-east and b-south pass-through, clear input and enable input; instanced MxN times.

Test Plan:
- 4x3·3x2 run, acc_mode=0. A=[[1,2,0],[3,4,0],[5,6,0],[1,0,1]], B=[[1,0],[0,1],[2,1]] -> C=[[1,2],[3,4],[5,6],[3,1]] (0x0100, 0x0200, ...). First c_valid exactly 8 cycles after start; done after 8 accepted elements.
- Repeat the same run with acc_mode=1 -> C=[[2,4],[6,8],[10,12],[6,2]].
- Backpressure: c_ready=0 for 3 cycles while element (1,0) is presented -> c_data=0x0300, c_row=1, c_col=0 held stable. No element lost or duplicated; done only after all 8 are accepted.
- Negative/floor: A[0][0]=-1.5 (0xFE80), B[0][0]=2.0 (0x0200), all other entries 0 -> C[0][0]=0xFD00; others 0.
- Overflow: A[0][0]=100.0, B[0][0]=100.0 -> with SYSTOLIC_SAT_EN, C[0][0]=0x7FFF and ovf=1. Without it, C[0][0]=0x1000 and ovf=0.
- Abort: rst_n low mid-FEED -> busy=0, c_valid=0, no done. Clean rerun of the first scenario passes.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM states, accumulator width helper and fixed-point narrowing
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, FEED, OUTPUT, DONE} state_t;
  localparam int MAX_W = 128;
  function automatic int acc_width(input int dw, input int k, input int guard);
    return 2 * dw + $clog2(k) + guard;
  endfunction
  // Clamp to the signed dw-bit range when sat is set; otherwise pass through so the
  // caller's truncation wraps.
  function automatic logic signed [MAX_W-1:0] narrow(input logic signed [MAX_W-1:0] x,
                                                     input int dw, input bit sat);
    logic signed [MAX_W-1:0] hi, lo;
    hi = (MAX_W'(1) << (dw - 1)) - MAX_W'(1);
    lo = -hi - MAX_W'(1);
    return !sat ? x : x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/systolic_matmul_acc_pe.sv
// systolic_pe: output-stationary MAC cell with registered east/south operand pass-through
// ports: clk, rst_n (async low), en (accumulate + shift), clr (zero accumulator),
//        a_in/b_in operands in, a_out/b_out operands to east/south neighbours, acc sum
module systolic_pe #(
  parameter int DW = 16,
  parameter int AW = 38
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic signed [AW-1:0] acc
);
  logic signed [2*DW-1:0] prod;
  assign prod = a_in * b_in;
  // Pass-through registers drain to zero outside FEED so the next run starts bubble-clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= en ? a_in : '0;
      b_out <= en ? b_in : '0;
      acc   <= clr ? '0 : en ? acc + AW'(prod) : acc;
    end
  end
endmodule

// File: rtl/systolic_matmul_acc.sv
// systolic_matmul_acc: MxN output-stationary systolic C = A*B with tile accumulation
// ports: clk, rst_n (async low); start/acc_mode run control; a_*/b_* element writes (IDLE only);
//        c_data/c_row/c_col/c_valid with c_ready backpressure; busy, done pulse, sticky ovf
// build option: SYSTOLIC_SAT_EN enables saturation and ovf; otherwise results wrap
module systolic_matmul_acc
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int M          = 4,
  parameter int N          = 2,
  parameter int K          = 3,
  parameter int ACC_GUARD  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  acc_mode,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [$clog2(M)-1:0]  a_row,
  input  logic [$clog2(K)-1:0]  a_col,
  input  logic                  a_valid,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic [$clog2(K)-1:0]  b_row,
  input  logic [$clog2(N)-1:0]  b_col,
  input  logic                  b_valid,
  output logic [DATA_WIDTH-1:0] c_data,
  output logic [$clog2(M)-1:0]  c_row,
  output logic [$clog2(N)-1:0]  c_col,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, K, ACC_GUARD);
  localparam int S = M + N + K - 2;
`ifdef SYSTOLIC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  state_t st, nxt;
  logic [$clog2(S)-1:0] step;
  logic signed [DATA_WIDTH-1:0] abuf [M][K];
  logic signed [DATA_WIDTH-1:0] bbuf [K][N];
  logic signed [DATA_WIDTH-1:0] a_feed [M];
  logic signed [DATA_WIDTH-1:0] b_feed [N];
  logic signed [DATA_WIDTH-1:0] a_w [M][N+1];
  logic signed [DATA_WIDTH-1:0] b_w [M+1][N];
  logic signed [ACC_WIDTH-1:0] acc [M][N];
  logic signed [ACC_WIDTH-1:0] sel;
  logic signed [MAX_W-1:0] wide, nar;
  logic [$clog2(M)-1:0] nr;
  logic [$clog2(N)-1:0] nc;
  logic fin, go, en, clr, load, el_ovf;
  assign go    = st == IDLE && start;
  assign en    = st == FEED;
  assign clr   = go && !acc_mode;
  assign load  = st == OUTPUT && (!c_valid || c_ready);
  assign busy  = st != IDLE;
  assign done  = st == DONE;
  assign sel   = acc[nr][nc];
  assign wide  = MAX_W'(sel >>> FRAC_WIDTH);
  assign nar   = narrow(wide, DATA_WIDTH, SAT);
  assign el_ovf = nar != wide;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  end
  always_comb begin
    nxt = st == IDLE   ? (start ? FEED : IDLE) :
          st == FEED   ? (32'(step) == S - 1 ? OUTPUT : FEED) :
          st == OUTPUT ? (load && fin ? DONE : OUTPUT) : IDLE;
  end
  // Row i is skewed by i and column j by j: element k enters at step i+k / j+k.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      a_feed[i] = '0;
      for (int k = 0; k < K; k++) if (32'(step) == i + k) a_feed[i] = abuf[i][k];
    end
    for (int j = 0; j < N; j++) begin
      b_feed[j] = '0;
      for (int k = 0; k < K; k++) if (32'(step) == j + k) b_feed[j] = bbuf[k][j];
    end
  end
  for (genvar i = 0; i < M; i++) begin : g_row
    assign a_w[i][0] = a_feed[i];
  end
  for (genvar j = 0; j < N; j++) begin : g_col
    assign b_w[0][j] = b_feed[j];
  end
  for (genvar i = 0; i < M; i++) begin : g_pi
    for (genvar j = 0; j < N; j++) begin : g_pj
      systolic_pe #(.DW(DATA_WIDTH), .AW(ACC_WIDTH)) u_pe (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (clr),
        .a_in (a_w[i][j]),
        .b_in (b_w[i][j]),
        .a_out(a_w[i][j+1]),
        .b_out(b_w[i+1][j]),
        .acc  (acc[i][j])
      );
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) abuf[i][k] <= '0;
      for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) bbuf[k][j] <= '0;
      step    <= '0;
      nr      <= '0;
      nc      <= '0;
      fin     <= 1'b0;
      c_data  <= '0;
      c_row   <= '0;
      c_col   <= '0;
      c_valid <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (st == IDLE && a_valid && 32'(a_row) < M && 32'(a_col) < K) abuf[a_row][a_col] <= a_data;
      if (st == IDLE && b_valid && 32'(b_row) < K && 32'(b_col) < N) bbuf[b_row][b_col] <= b_data;
      if (go) begin
        step <= '0;
        nr   <= '0;
        nc   <= '0;
        fin  <= 1'b0;
        ovf  <= 1'b0;
      end
      if (en) step <= step + 1'b1;
      // One element is registered one cycle ahead; fin marks that the last one is out.
      if (load) begin
        c_valid <= !fin;
        if (!fin) begin
          c_data <= nar[DATA_WIDTH-1:0];
          c_row  <= nr;
          c_col  <= nc;
          ovf    <= ovf | el_ovf;
          fin    <= 32'(nr) == M - 1 && 32'(nc) == N - 1;
          nc     <= 32'(nc) == N - 1 ? '0 : nc + 1'b1;
          nr     <= 32'(nc) == N - 1 ? nr + 1'b1 : nr;
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_matmul_acc.sv
// tb_systolic_matmul_acc: directed self-checking bench for systolic_matmul_acc
module tb_systolic_matmul_acc;
  logic clk = 0, rst_n = 0, start = 0, acc_mode = 0;
  logic [15:0] a_data = 0, b_data = 0, c_data;
  logic [1:0] a_row = 0, a_col = 0, b_row = 0, c_row;
  logic b_col = 0, c_col;
  logic a_valid = 0, b_valid = 0, c_valid, c_ready = 1, busy, done, ovf;
  int checks = 0, failures = 0;
  logic [15:0] ma [4][3];
  logic [15:0] mb [3][2];
  logic [15:0] ec [4][2];
`ifdef SYSTOLIC_SAT_EN
  localparam bit SAT = 1;
`else
  localparam bit SAT = 0;
`endif
  systolic_matmul_acc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode),
    .a_data(a_data), .a_row(a_row), .a_col(a_col), .a_valid(a_valid),
    .b_data(b_data), .b_row(b_row), .b_col(b_col), .b_valid(b_valid),
    .c_data(c_data), .c_row(c_row), .c_col(c_col), .c_valid(c_valid), .c_ready(c_ready),
    .busy(busy), .done(done), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clear_mats();
    for (int i = 0; i < 4; i++) for (int k = 0; k < 3; k++) ma[i][k] = 0;
    for (int k = 0; k < 3; k++) for (int j = 0; j < 2; j++) mb[k][j] = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 2; j++) ec[i][j] = 0;
  endtask
  task automatic set_first();
    clear_mats();
    ma[0][0] = 16'h0100; ma[0][1] = 16'h0200;
    ma[1][0] = 16'h0300; ma[1][1] = 16'h0400;
    ma[2][0] = 16'h0500; ma[2][1] = 16'h0600;
    ma[3][0] = 16'h0100; ma[3][2] = 16'h0100;
    mb[0][0] = 16'h0100; mb[1][1] = 16'h0100; mb[2][0] = 16'h0200; mb[2][1] = 16'h0100;
    ec[0][0] = 16'h0100; ec[0][1] = 16'h0200; ec[1][0] = 16'h0300; ec[1][1] = 16'h0400;
    ec[2][0] = 16'h0500; ec[2][1] = 16'h0600; ec[3][0] = 16'h0300; ec[3][1] = 16'h0100;
  endtask
  task automatic write_mats();
    for (int n = 0; n < 12; n++) begin
      a_valid = 1; a_row = 2'(n / 3); a_col = 2'(n % 3); a_data = ma[n / 3][n % 3];
      b_valid = n < 6; b_row = 2'(n / 2 % 3); b_col = 1'(n % 2); b_data = mb[n / 2 % 3][n % 2];
      @(negedge clk);
    end
    a_valid = 0; b_valid = 0;
  endtask
  task automatic run(input logic am, input int stall, input logic eovf);
    int lat, got, guard;
    start = 1; acc_mode = am;
    @(negedge clk);
    start = 0;
    chk("busy_run", busy, 1);
    lat = 0;
    while (!c_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 8);
    got = 0; guard = 0;
    while (got < 8 && guard < 60) begin
      guard++;
      if (c_valid) begin
        chk("c_row", c_row, got / 2);
        chk("c_col", c_col, got % 2);
        chk("c_data", c_data, ec[got / 2][got % 2]);
        chk("done_early", done, 0);
        if (got == stall) begin
          c_ready = 0;
          repeat (3) begin
            @(negedge clk);
            chk("hold_valid", c_valid, 1);
            chk("hold_data", c_data, ec[got / 2][got % 2]);
            chk("hold_row", c_row, got / 2);
            chk("hold_col", c_col, got % 2);
            chk("hold_done", done, 0);
          end
          c_ready = 1;
        end
        got++;
      end
      @(negedge clk);
    end
    chk("elem_count", got, 8);
    chk("done", done, 1);
    chk("busy_done", busy, 1);
    chk("valid_off", c_valid, 0);
    chk("ovf", ovf, eovf);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("done_pulse", done, 0);
  endtask
  initial begin
    int seen;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", c_valid, 0);
    chk("rst_data", c_data, 0);
    chk("rst_rowcol", {c_row, c_col}, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1;
    @(negedge clk);
    set_first();
    write_mats();
    run(0, 2, 0);
    ec[0][0] = 16'h0200; ec[0][1] = 16'h0400; ec[1][0] = 16'h0600; ec[1][1] = 16'h0800;
    ec[2][0] = 16'h0A00; ec[2][1] = 16'h0C00; ec[3][0] = 16'h0600; ec[3][1] = 16'h0200;
    run(1, -1, 0);
    clear_mats();
    ma[0][0] = 16'hFE80; ma[1][0] = 16'hFFFF; mb[0][0] = 16'h0200; mb[0][1] = 16'h0080;
    ec[0][0] = 16'hFD00; ec[0][1] = 16'hFF40; ec[1][0] = 16'hFFFE; ec[1][1] = 16'hFFFF;
    write_mats();
    run(0, -1, 0);
    clear_mats();
    ma[0][0] = 16'h6400; mb[0][0] = 16'h6400;
    ec[0][0] = SAT ? 16'h7FFF : 16'h1000;
    write_mats();
    run(0, -1, SAT);
    set_first();
    write_mats();
    start = 1; acc_mode = 0;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", c_valid, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || c_valid) seen++;
    end
    chk("abort_quiet", seen, 0);
    chk("abort_idle", busy, 0);
    write_mats();
    run(0, -1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
